// File: rtl/tick_counter_pkg.sv
// Shared definitions for the tick counter: FSM encodings and default sizing.
// Imported by the interface, the edge detector and the top level.
package tick_counter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MODULUS = 10;

endpackage

// File: rtl/tick_counter_if.sv
// Bus between the tick counter and its host: divider taps, control strobes and count status.
// The master side drives the controls; the slave side is the counter itself.
interface tick_counter_if
    import tick_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [3:0]       ClkDiv;
    logic [1:0]       Sel;
    logic             Start;
    logic             Stop;
    logic             Up;
    logic             Load;
    logic [WIDTH-1:0] LoadVal;
    logic [WIDTH-1:0] Count;
    logic             Tick;
    logic             Wrap;
    logic             Running;

    modport master (
        output ClkDiv, Sel, Start, Stop, Up, Load, LoadVal,
        input  Count, Tick, Wrap, Running
    );

    modport slave (
        input  ClkDiv, Sel, Start, Stop, Up, Load, LoadVal,
        output Count, Tick, Wrap, Running
    );

endinterface

// File: rtl/tick_counter_edge_tick_detect.sv
// Picks one divider tap and turns its rising edges into single-cycle ticks in the ClkIn domain.
// A change of Sel blanks the tick for that cycle so switching taps never fakes an edge.
module edge_tick_detect
    import tick_counter_pkg::*;
(
    input  logic       ClkIn,
    input  logic       Reset,
    input  logic [3:0] ClkDiv,
    input  logic [1:0] Sel,
    output logic       Tick
);

    logic       selBit;
    logic       prevBit_q;
    logic [1:0] selQ_q;
    logic       tick_q;
    logic       tick_d;

    assign selBit = ClkDiv[Sel];

    always_comb begin
        tick_d = selBit & ~prevBit_q & (Sel == selQ_q);
    end

    // History is primed from the live tap during reset so release cannot look like an edge.
    always_ff @(posedge ClkIn) begin
        if (Reset) begin
            prevBit_q <= selBit;
            selQ_q    <= Sel;
            tick_q    <= 1'b0;
        end else begin
            prevBit_q <= selBit;
            selQ_q    <= Sel;
            tick_q    <= tick_d;
        end
    end

    assign Tick = tick_q;

endmodule

// File: rtl/tick_counter.sv
// Modulo-MODULUS up/down counter advanced by divider ticks, with load, run/stop FSM and wrap pulse.
// Everything runs on ClkIn; the divider taps are only ever sampled, never used as clocks.
module tick_counter
    import tick_counter_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int MODULUS = DEF_MODULUS
) (
    input  logic ClkIn,
    input  logic Reset,
    tick_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             tick;
    logic             running;

    edge_tick_detect u_edge (
        .ClkIn  (ClkIn),
        .Reset  (Reset),
        .ClkDiv (bus.ClkDiv),
        .Sel    (bus.Sel),
        .Tick   (tick)
    );

    always_ff @(posedge ClkIn) begin
        if (Reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop always dominates Start, whichever state we are in.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.Start && !bus.Stop) state_d = ST_RUN;
            ST_RUN:  if (bus.Stop)               state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        running = (state_q == ST_RUN);
    end

    // Load beats a tick; a tick only counts while the FSM is currently in RUN.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.Load) begin
            count_d = (bus.LoadVal > MAX_VAL) ? MAX_VAL : bus.LoadVal;
        end else if (tick && running) begin
            if (bus.Up) begin
                if (count_q == MAX_VAL) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_VAL;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge ClkIn) begin
        if (Reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.Count   = count_q;
    assign bus.Tick    = tick;
    assign bus.Wrap    = wrap_q;
    assign bus.Running = running;

endmodule

// File: tb/tb_tick_counter.sv
// Directed bench for tick_counter (WIDTH=4, MODULUS=10): reset, up/down wrap, load, stop and tap switching.
// Inputs change and outputs are sampled 1ns after each rising edge of ClkIn.
module tb_tick_counter;
    import tick_counter_pkg::*;

    localparam int W = 4;
    localparam int M = 10;

    logic ClkIn;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;

    tick_counter_if #(.WIDTH(W)) bus ();

    tick_counter #(.WIDTH(W), .MODULUS(M)) dut (
        .ClkIn (ClkIn),
        .Reset (Reset),
        .bus   (bus)
    );

    initial ClkIn = 1'b0;
    always #5 ClkIn = ~ClkIn;

    task automatic step;
        @(posedge ClkIn);
        #1;
    endtask

    // One low-then-high cycle of tap b; returns Tick as seen in the cycle after the rise,
    // and leaves the bench one cycle later where the counter has absorbed that tick.
    task automatic pulseSrc(input int b, output logic tickSeen);
        bus.ClkDiv[b] = 1'b0;
        step;
        step;
        bus.ClkDiv[b] = 1'b1;
        step;
        tickSeen = bus.Tick;
        step;
    endtask

    task automatic test_reset;
        Reset       = 1'b1;
        bus.ClkDiv  = 4'b0001;
        bus.Sel     = 2'd0;
        bus.Start   = 1'b0;
        bus.Stop    = 1'b0;
        bus.Up      = 1'b1;
        bus.Load    = 1'b0;
        bus.LoadVal = '0;
        repeat (3) step;
        checks++; if (bus.Count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", bus.Count); end
        checks++; if (bus.Running !== 1'b0) begin failures++; $display("[TB] FAIL reset_running got=%b exp=0", bus.Running); end
        checks++; if (bus.Wrap !== 1'b0) begin failures++; $display("[TB] FAIL reset_wrap got=%b exp=0", bus.Wrap); end
        checks++; if (bus.Tick !== 1'b0) begin failures++; $display("[TB] FAIL reset_tick got=%b exp=0", bus.Tick); end
        Reset = 1'b0;
        step;
        checks++; if (bus.Tick !== 1'b0) begin failures++; $display("[TB] FAIL release_tick got=%b exp=0", bus.Tick); end
        checks++; if (bus.Count !== 4'd0) begin failures++; $display("[TB] FAIL release_count got=%0d exp=0", bus.Count); end
    endtask

    task automatic test_count_up;
        logic t;
        bus.Up    = 1'b1;
        bus.Start = 1'b1;
        step;
        bus.Start = 1'b0;
        checks++; if (bus.Running !== 1'b1) begin failures++; $display("[TB] FAIL start_running got=%b exp=1", bus.Running); end
        for (int i = 1; i <= M; i++) begin
            pulseSrc(0, t);
            checks++; if (t !== 1'b1) begin failures++; $display("[TB] FAIL up_tick[%0d] got=%b exp=1", i, t); end
            checks++; if (bus.Count !== 4'(i % M)) begin failures++; $display("[TB] FAIL up_count[%0d] got=%0d exp=%0d", i, bus.Count, i % M); end
            checks++; if (bus.Wrap !== logic'(i == M)) begin failures++; $display("[TB] FAIL up_wrap[%0d] got=%b exp=%b", i, bus.Wrap, (i == M)); end
        end
        step;
        checks++; if (bus.Wrap !== 1'b0) begin failures++; $display("[TB] FAIL up_wrap_width got=%b exp=0", bus.Wrap); end
        checks++; if (bus.Count !== 4'd0) begin failures++; $display("[TB] FAIL up_hold got=%0d exp=0", bus.Count); end
    endtask

    task automatic test_count_down;
        logic t;
        bus.Up = 1'b0;
        pulseSrc(0, t);
        checks++; if (bus.Count !== 4'd9) begin failures++; $display("[TB] FAIL down_wrap_count got=%0d exp=9", bus.Count); end
        checks++; if (bus.Wrap !== 1'b1) begin failures++; $display("[TB] FAIL down_wrap got=%b exp=1", bus.Wrap); end
        pulseSrc(0, t);
        checks++; if (bus.Count !== 4'd8) begin failures++; $display("[TB] FAIL down_count got=%0d exp=8", bus.Count); end
        checks++; if (bus.Wrap !== 1'b0) begin failures++; $display("[TB] FAIL down_nowrap got=%b exp=0", bus.Wrap); end
    endtask

    task automatic test_load;
        bus.Stop = 1'b1;
        step;
        bus.Stop = 1'b0;
        checks++; if (bus.Running !== 1'b0) begin failures++; $display("[TB] FAIL stop_running got=%b exp=0", bus.Running); end
        bus.Load    = 1'b1;
        bus.LoadVal = 4'd13;
        step;
        bus.Load = 1'b0;
        checks++; if (bus.Count !== 4'd9) begin failures++; $display("[TB] FAIL load_clamp got=%0d exp=9", bus.Count); end
        bus.Start = 1'b1;
        step;
        bus.Start = 1'b0;
        checks++; if (bus.Running !== 1'b1) begin failures++; $display("[TB] FAIL load_start got=%b exp=1", bus.Running); end
        bus.Up        = 1'b1;
        bus.ClkDiv[0] = 1'b0;
        step;
        step;
        bus.ClkDiv[0] = 1'b1;
        step;
        checks++; if (bus.Tick !== 1'b1) begin failures++; $display("[TB] FAIL load_tick got=%b exp=1", bus.Tick); end
        bus.Load    = 1'b1;
        bus.LoadVal = 4'd4;
        step;
        bus.Load = 1'b0;
        checks++; if (bus.Count !== 4'd4) begin failures++; $display("[TB] FAIL load_vs_tick got=%0d exp=4", bus.Count); end
        checks++; if (bus.Wrap !== 1'b0) begin failures++; $display("[TB] FAIL load_wrap got=%b exp=0", bus.Wrap); end
    endtask

    task automatic test_stop;
        logic t;
        bus.Stop = 1'b1;
        step;
        bus.Stop = 1'b0;
        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        step;
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        checks++; if (bus.Running !== 1'b0) begin failures++; $display("[TB] FAIL start_stop_idle got=%b exp=0", bus.Running); end
        pulseSrc(0, t);
        checks++; if (t !== 1'b1) begin failures++; $display("[TB] FAIL idle_tick got=%b exp=1", t); end
        checks++; if (bus.Count !== 4'd4) begin failures++; $display("[TB] FAIL idle_hold got=%0d exp=4", bus.Count); end
        bus.Load    = 1'b1;
        bus.LoadVal = 4'd5;
        step;
        bus.Load  = 1'b0;
        bus.Start = 1'b1;
        step;
        bus.Start = 1'b0;
        checks++; if (bus.Running !== 1'b1) begin failures++; $display("[TB] FAIL restart got=%b exp=1", bus.Running); end
        bus.ClkDiv[0] = 1'b0;
        step;
        step;
        bus.ClkDiv[0] = 1'b1;
        step;
        bus.Stop = 1'b1;
        step;
        bus.Stop = 1'b0;
        checks++; if (bus.Count !== 4'd6) begin failures++; $display("[TB] FAIL stop_tick_count got=%0d exp=6", bus.Count); end
        checks++; if (bus.Running !== 1'b0) begin failures++; $display("[TB] FAIL stop_tick_running got=%b exp=0", bus.Running); end
        pulseSrc(0, t);
        checks++; if (bus.Count !== 4'd6) begin failures++; $display("[TB] FAIL after_stop_hold got=%0d exp=6", bus.Count); end
    endtask

    task automatic test_sel_switch;
        logic t;
        bus.Start = 1'b1;
        step;
        bus.Start  = 1'b0;
        bus.ClkDiv = 4'b1000;
        step;
        step;
        bus.Sel = 2'd3;
        step;
        checks++; if (bus.Tick !== 1'b0) begin failures++; $display("[TB] FAIL sel_switch_tick got=%b exp=0", bus.Tick); end
        step;
        checks++; if (bus.Tick !== 1'b0) begin failures++; $display("[TB] FAIL sel_after_tick got=%b exp=0", bus.Tick); end
        checks++; if (bus.Count !== 4'd6) begin failures++; $display("[TB] FAIL sel_hold got=%0d exp=6", bus.Count); end
        pulseSrc(3, t);
        checks++; if (t !== 1'b1) begin failures++; $display("[TB] FAIL sel3_tick got=%b exp=1", t); end
        checks++; if (bus.Count !== 4'd7) begin failures++; $display("[TB] FAIL sel3_count got=%0d exp=7", bus.Count); end
        bus.ClkDiv[0] = 1'b1;
        step;
        checks++; if (bus.Tick !== 1'b0) begin failures++; $display("[TB] FAIL unselected_tick got=%b exp=0", bus.Tick); end
        step;
        checks++; if (bus.Count !== 4'd7) begin failures++; $display("[TB] FAIL unselected_count got=%0d exp=7", bus.Count); end
    endtask

    task automatic test_reset_mid;
        Reset = 1'b1;
        step;
        checks++; if (bus.Count !== 4'd0) begin failures++; $display("[TB] FAIL mid_reset_count got=%0d exp=0", bus.Count); end
        checks++; if (bus.Running !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_running got=%b exp=0", bus.Running); end
        Reset = 1'b0;
        step;
        checks++; if (bus.Tick !== 1'b0) begin failures++; $display("[TB] FAIL mid_release_tick got=%b exp=0", bus.Tick); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_stop();
        test_sel_switch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
